// File: rtl/array_access_unit.sv
// -----------------------------------------------------------------------------
// array_access_unit
//
// Purpose:
//   Initiator side of the array memory request/done handshake. Takes an
//   iaload/iastore request from the execute stage (array base, length, signed
//   index, store value), bounds-checks the index, fires a single trigger pulse
//   at the attached array block, waits for its done pulse, and hands the load
//   data (or an out-of-bounds / timeout flag) back to the execute stage.
//
// Parameters:
//   ARR_SIZE  words in the attached array block (address width is
//             $clog2(ARR_SIZE), called ADDR below)
//   TIMEOUT   WAIT cycles tolerated without mem_done before aborting
//             (only meaningful when ARRAY_ACCESS_TIMEOUT_EN is defined)
//
// Ports:
//   clk, rst      clock (posedge) and synchronous active-high reset
//   req_valid     request present            req_ready   high only in IDLE
//   req_store     1 = iastore, 0 = iaload    req_base    array start word
//   req_length    array length (ADDR+1 b)    req_index   signed element index
//   req_wdata     store value
//   resp_valid    one-cycle completion pulse
//   resp_data     load data (0 for stores, out-of-bounds and timeout)
//   resp_oob      index out of bounds, no memory access made
//   resp_timeout  mem_done never arrived
//   mem_trigger   one-cycle access start pulse to the array block
//   mem_write     write enable             mem_addr    word address
//   mem_wdata     write data               mem_rdata   read data (with done)
//   mem_done      one-cycle access-complete pulse from the array block
//
// Configuration macro:
//   ARRAY_ACCESS_TIMEOUT_EN  when defined, WAIT is abandoned after TIMEOUT
//                            cycles without mem_done and resp_timeout is
//                            reported; when undefined, WAIT lasts until
//                            mem_done and resp_timeout is constant 0.
//
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module array_access_unit #(
  parameter int ARR_SIZE = 1024,
  parameter int TIMEOUT  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_store,
  input  logic [$clog2(ARR_SIZE)-1:0]   req_base,
  input  logic [$clog2(ARR_SIZE):0]     req_length,
  input  logic [31:0]                   req_index,
  input  logic [31:0]                   req_wdata,
  output logic                          resp_valid,
  output logic [31:0]                   resp_data,
  output logic                          resp_oob,
  output logic                          resp_timeout,
  output logic                          mem_trigger,
  output logic                          mem_write,
  output logic [$clog2(ARR_SIZE)-1:0]   mem_addr,
  output logic [31:0]                   mem_wdata,
  input  logic [31:0]                   mem_rdata,
  input  logic                          mem_done
);

  localparam int ADDR = $clog2(ARR_SIZE);

  // Array size expressed at the width of the bounds-check sum.
  localparam logic [ADDR:0] ARR_LIMIT = (ADDR + 1)'(ARR_SIZE);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t state_reg, state_next;

  // Latched request fields.
  logic            store_reg,  store_next;
  logic [ADDR-1:0] base_reg,   base_next;
  logic [ADDR:0]   length_reg, length_next;
  logic [31:0]     index_reg,  index_next;
  logic [31:0]     wdata_reg,  wdata_next;

  // Output registers.
  logic            req_ready_reg,   req_ready_next;
  logic            resp_valid_reg,  resp_valid_next;
  logic [31:0]     resp_data_reg,   resp_data_next;
  logic            resp_oob_reg,    resp_oob_next;
  logic            mem_trigger_reg, mem_trigger_next;
  logic            mem_write_reg,   mem_write_next;
  logic [ADDR-1:0] mem_addr_reg,    mem_addr_next;
  logic [31:0]     mem_wdata_reg,   mem_wdata_next;

`ifdef ARRAY_ACCESS_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  // Count value seen on the last permitted WAIT cycle.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  logic             resp_timeout_reg, resp_timeout_next;
  logic [TMO_W-1:0] tmo_cnt_reg,      tmo_cnt_next;
`endif

  // ---------------------------------------------------------------------------
  // Bounds check on the latched request (evaluated in CHECK).
  // ---------------------------------------------------------------------------
  logic          idx_neg;
  logic          idx_ge_len;
  logic          idx_hi;
  logic [ADDR:0] addr_sum;
  logic          sum_oob;
  logic          oob;

  always_comb begin
    // Signed index: sign bit set means negative.
    idx_neg    = index_reg[31];
    // Length is unsigned; zero-extend to the index width for the compare.
    idx_ge_len = (index_reg >= {{(31 - ADDR){1'b0}}, length_reg});
    // Any index bit above the address field already puts base+index past the
    // array, and would otherwise be lost by the ADDR-bit truncation below.
    idx_hi     = |index_reg[31:ADDR];
    // One extra bit so base+index cannot wrap back into the array.
    addr_sum   = {1'b0, base_reg} + {1'b0, index_reg[ADDR-1:0]};
    sum_oob    = (addr_sum >= ARR_LIMIT);
    oob        = idx_neg | idx_ge_len | idx_hi | sum_oob;
  end

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next       = state_reg;

    store_next       = store_reg;
    base_next        = base_reg;
    length_next      = length_reg;
    index_next       = index_reg;
    wdata_next       = wdata_reg;

    // Pulses and response fields are only ever high for one cycle, so they
    // default to 0 and are set on the transition into the state that shows
    // them.
    req_ready_next   = 1'b0;
    resp_valid_next  = 1'b0;
    resp_data_next   = '0;
    resp_oob_next    = 1'b0;
    mem_trigger_next = 1'b0;

    // Memory-side fields hold between accesses.
    mem_write_next   = mem_write_reg;
    mem_addr_next    = mem_addr_reg;
    mem_wdata_next   = mem_wdata_reg;

`ifdef ARRAY_ACCESS_TIMEOUT_EN
    resp_timeout_next = 1'b0;
    tmo_cnt_next      = tmo_cnt_reg;
`endif

    case (state_reg)
      ST_IDLE: begin
        req_ready_next = 1'b1;
        if (req_valid && req_ready_reg) begin
          store_next     = req_store;
          base_next      = req_base;
          length_next    = req_length;
          index_next     = req_index;
          wdata_next     = req_wdata;
          req_ready_next = 1'b0;
          state_next     = ST_CHECK;
        end
      end

      ST_CHECK: begin
        if (oob) begin
          // Rejected without touching the array block.
          resp_valid_next = 1'b1;
          resp_oob_next   = 1'b1;
          state_next      = ST_RESP;
        end else begin
          mem_addr_next    = addr_sum[ADDR-1:0];
          mem_write_next   = store_reg;
          mem_wdata_next   = wdata_reg;
          mem_trigger_next = 1'b1;
          state_next       = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        // mem_trigger drops as we leave; address/data stay put through WAIT.
        state_next = ST_WAIT;
`ifdef ARRAY_ACCESS_TIMEOUT_EN
        tmo_cnt_next = '0;
`endif
      end

      ST_WAIT: begin
        if (mem_done) begin
          resp_valid_next = 1'b1;
          resp_data_next  = store_reg ? 32'd0 : mem_rdata;
          mem_write_next  = 1'b0;
          state_next      = ST_RESP;
        end
`ifdef ARRAY_ACCESS_TIMEOUT_EN
        else if (tmo_cnt_reg == TMO_LAST) begin
          resp_valid_next   = 1'b1;
          resp_timeout_next = 1'b1;
          mem_write_next    = 1'b0;
          state_next        = ST_RESP;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + 1'b1;
        end
`endif
      end

      ST_RESP: begin
        // Response fields fall back to their 0 defaults here.
        req_ready_next = 1'b1;
        state_next     = ST_IDLE;
      end

      default: begin
        req_ready_next = 1'b1;
        state_next     = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      store_reg       <= 1'b0;
      base_reg        <= '0;
      length_reg      <= '0;
      index_reg       <= '0;
      wdata_reg       <= '0;
      req_ready_reg   <= 1'b1;
      resp_valid_reg  <= 1'b0;
      resp_data_reg   <= '0;
      resp_oob_reg    <= 1'b0;
      mem_trigger_reg <= 1'b0;
      mem_write_reg   <= 1'b0;
      mem_addr_reg    <= '0;
      mem_wdata_reg   <= '0;
    end else begin
      state_reg       <= state_next;
      store_reg       <= store_next;
      base_reg        <= base_next;
      length_reg      <= length_next;
      index_reg       <= index_next;
      wdata_reg       <= wdata_next;
      req_ready_reg   <= req_ready_next;
      resp_valid_reg  <= resp_valid_next;
      resp_data_reg   <= resp_data_next;
      resp_oob_reg    <= resp_oob_next;
      mem_trigger_reg <= mem_trigger_next;
      mem_write_reg   <= mem_write_next;
      mem_addr_reg    <= mem_addr_next;
      mem_wdata_reg   <= mem_wdata_next;
    end
  end

`ifdef ARRAY_ACCESS_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_timeout_reg <= 1'b0;
      tmo_cnt_reg      <= '0;
    end else begin
      resp_timeout_reg <= resp_timeout_next;
      tmo_cnt_reg      <= tmo_cnt_next;
    end
  end

  assign resp_timeout = resp_timeout_reg;
`else
  assign resp_timeout = 1'b0;
`endif

  assign req_ready   = req_ready_reg;
  assign resp_valid  = resp_valid_reg;
  assign resp_data   = resp_data_reg;
  assign resp_oob    = resp_oob_reg;
  assign mem_trigger = mem_trigger_reg;
  assign mem_write   = mem_write_reg;
  assign mem_addr    = mem_addr_reg;
  assign mem_wdata   = mem_wdata_reg;

endmodule

// File: tb/tb_array_access_unit.sv
// -----------------------------------------------------------------------------
// tb_array_access_unit
//
// Directed bench for array_access_unit. A small array-block model answers
// each trigger with done three cycles after the trigger rises (read data
// valid with done, writes applied on the same edge). Latency is counted in
// clock edges from the accept edge to the edge at which resp_valid is first
// sampled high; the bench observes outputs on the falling edge.
// Define ARRAY_ACCESS_TIMEOUT_EN for both RTL and bench to exercise the
// timeout path.
// -----------------------------------------------------------------------------
module tb_array_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [9:0]  req_base;
  logic [10:0] req_length;
  logic [31:0] req_index;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_oob;
  logic        resp_timeout;
  logic        mem_trigger;
  logic        mem_write;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;

  array_access_unit #(.ARR_SIZE(1024), .TIMEOUT(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_store    (req_store),
    .req_base     (req_base),
    .req_length   (req_length),
    .req_index    (req_index),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .resp_oob     (resp_oob),
    .resp_timeout (resp_timeout),
    .mem_trigger  (mem_trigger),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_done     (mem_done)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Array block model
  // ---------------------------------------------------------------------------
  logic [31:0] mem [0:1023];
  logic        stub_en;
  logic        stray_done;
  logic        pre_we;
  logic [9:0]  pre_addr;
  logic [31:0] pre_data;
  logic        t1, t2;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    if (rst) begin
      t1        <= 1'b0;
      t2        <= 1'b0;
      mem_done  <= 1'b0;
      mem_rdata <= 32'd0;
    end else begin
      t1        <= mem_trigger & stub_en;
      t2        <= t1;
      mem_done  <= t2 | stray_done;
      mem_rdata <= 32'd0;
      if (t2) begin
        if (mem_write) mem[mem_addr] <= mem_wdata;
        else           mem_rdata     <= mem[mem_addr];
      end
    end
  end

  // Trigger monitor
  int          trig_cnt = 0;
  logic [9:0]  trig_addr = '0;
  logic        trig_write = 1'b0;

  always @(posedge clk) begin
    if (mem_trigger) begin
      trig_cnt   <= trig_cnt + 1;
      trig_addr  <= mem_addr;
      trig_write <= mem_write;
    end
  end

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  int          checks = 0;
  int          errors = 0;
  logic        got_valid;
  logic [31:0] got_data;
  logic        got_oob;
  logic        got_tmo;
  int          lat;
  int          t0;
  logic        seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  // Present one request and release it right after the accept edge.
  task automatic send(input logic st, input logic [9:0] base, input logic [10:0] len,
                      input logic [31:0] idx, input logic [31:0] wd);
    @(negedge clk);
    check("ready_at_req", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_store = st; req_base = base;
    req_length = len; req_index = idx; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Called just after the accept edge; bounded by 'limit' edges.
  task automatic wait_resp(input int limit, output int l);
    l = 1;
    @(negedge clk);
    while (resp_valid !== 1'b1 && l < limit) begin
      @(negedge clk);
      l++;
    end
    got_valid = resp_valid;
    got_data  = resp_data;
    got_oob   = resp_oob;
    got_tmo   = resp_timeout;
  endtask

  task automatic chk_resp(input string s, input int exp_lat, input logic [31:0] exp_data,
                          input logic exp_oob, input logic exp_tmo);
    check($sformatf("%s_valid", s), {31'd0, got_valid}, 32'd1);
    check($sformatf("%s_latency", s), lat, exp_lat);
    check($sformatf("%s_data", s), got_data, exp_data);
    check($sformatf("%s_oob", s), {31'd0, got_oob}, {31'd0, exp_oob});
    check($sformatf("%s_timeout", s), {31'd0, got_tmo}, {31'd0, exp_tmo});
  endtask

  // The cycle after a response: pulse gone, back in IDLE, memory side quiet.
  task automatic post_check(input string s);
    @(negedge clk);
    check($sformatf("%s_valid_clear", s), {31'd0, resp_valid}, 32'd0);
    check($sformatf("%s_ready_back", s), {31'd0, req_ready}, 32'd1);
    check($sformatf("%s_write_clear", s), {31'd0, mem_write}, 32'd0);
    check($sformatf("%s_trigger_low", s), {31'd0, mem_trigger}, 32'd0);
  endtask

  // Absolute guard against a hung run.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_base = '0;
    req_length = '0; req_index = '0; req_wdata = '0;
    stub_en = 1'b1; stray_done = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    repeat (3) @(posedge clk);

    // Release reset with a stray done pulse arriving right afterwards.
    @(negedge clk);
    rst = 1'b0; stray_done = 1'b1;
    @(posedge clk);
    #1 stray_done = 1'b0;
    @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_resp_oob", {31'd0, resp_oob}, 32'd0);
    check("rst_resp_timeout", {31'd0, resp_timeout}, 32'd0);
    check("rst_mem_trigger", {31'd0, mem_trigger}, 32'd0);
    check("rst_mem_write", {31'd0, mem_write}, 32'd0);
    check("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    check("stray_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("stray_ready", {31'd0, req_ready}, 32'd1);
    check("stray_trig_cnt", trig_cnt, 0);
    $display("step stray_done: ignored in IDLE");

    preload(10'h105, 32'hDEADBEEF);
    preload(10'h3FF, 32'hA5A50FF0);

    // 1: load base=0x100 len=8 idx=5
    t0 = trig_cnt;
    send(1'b0, 10'h100, 11'd8, 32'd5, 32'd0);
    wait_resp(30, lat);
    chk_resp("load5", 6, 32'hDEADBEEF, 1'b0, 1'b0);
    check("load5_trig_cnt", trig_cnt - t0, 1);
    check("load5_trig_addr", {22'd0, trig_addr}, 32'h105);
    check("load5_trig_write", {31'd0, trig_write}, 32'd0);
    post_check("load5");
    $display("step load idx=5: lat=%0d data=%h", lat, got_data);

    // 2: store idx=7 then load it back
    t0 = trig_cnt;
    send(1'b1, 10'h100, 11'd8, 32'd7, 32'h12345678);
    wait_resp(30, lat);
    chk_resp("store7", 6, 32'd0, 1'b0, 1'b0);
    check("store7_trig_addr", {22'd0, trig_addr}, 32'h107);
    check("store7_trig_write", {31'd0, trig_write}, 32'd1);
    check("store7_trig_cnt", trig_cnt - t0, 1);
    check("store7_mem", mem[10'h107], 32'h12345678);
    post_check("store7");
    $display("step store idx=7: lat=%0d data=%h", lat, got_data);

    send(1'b0, 10'h100, 11'd8, 32'd7, 32'd0);
    wait_resp(30, lat);
    chk_resp("load7", 6, 32'h12345678, 1'b0, 1'b0);
    post_check("load7");
    $display("step load idx=7: lat=%0d data=%h", lat, got_data);

    // 3: bounds
    t0 = trig_cnt;
    send(1'b1, 10'h100, 11'd8, 32'd8, 32'h0BAD0BAD);
    wait_resp(30, lat);
    chk_resp("oob_len", 2, 32'd0, 1'b1, 1'b0);
    post_check("oob_len");
    $display("step store idx=8 len=8: lat=%0d oob=%0d", lat, got_oob);

    send(1'b0, 10'h100, 11'd8, 32'hFFFFFFFF, 32'd0);
    wait_resp(30, lat);
    chk_resp("oob_neg", 2, 32'd0, 1'b1, 1'b0);
    post_check("oob_neg");
    $display("step load idx=-1: lat=%0d oob=%0d", lat, got_oob);

    send(1'b1, 10'h3FF, 11'd4, 32'd1, 32'h0BAD0BAD);
    wait_resp(30, lat);
    chk_resp("oob_wrap", 2, 32'd0, 1'b1, 1'b0);
    post_check("oob_wrap");
    check("oob_no_trigger", trig_cnt - t0, 0);
    check("oob_mem_105", mem[10'h105], 32'hDEADBEEF);
    check("oob_mem_3ff", mem[10'h3FF], 32'hA5A50FF0);
    $display("step store base=3FF idx=1: lat=%0d oob=%0d", lat, got_oob);

    // Last word of the array is still in bounds.
    send(1'b0, 10'h3FF, 11'd4, 32'd0, 32'd0);
    wait_resp(30, lat);
    chk_resp("top_word", 6, 32'hA5A50FF0, 1'b0, 1'b0);
    check("top_word_addr", {22'd0, trig_addr}, 32'h3FF);
    post_check("top_word");
    $display("step load base=3FF idx=0: lat=%0d data=%h", lat, got_data);

    // 4a: request held while busy; second one accepted only back in IDLE
    t0 = trig_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_base = 10'h100;
    req_length = 11'd8; req_index = 32'd5; req_wdata = 32'd0;
    @(posedge clk);
    #1 req_index = 32'd7;
    repeat (3) @(negedge clk);
    check("busy_ready_in_wait", {31'd0, req_ready}, 32'd0);
    repeat (3) @(negedge clk);
    check("busy_first_valid", {31'd0, resp_valid}, 32'd1);
    check("busy_first_data", resp_data, 32'hDEADBEEF);
    check("busy_one_trigger", trig_cnt - t0, 1);
    @(negedge clk);
    check("busy_ready_idle", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_resp(30, lat);
    chk_resp("busy_second", 6, 32'h12345678, 1'b0, 1'b0);
    check("busy_two_triggers", trig_cnt - t0, 2);
    post_check("busy_second");
    $display("step held request: second lat=%0d data=%h", lat, got_data);

    // 4b: reset while waiting on a store
    stub_en = 1'b0;
    send(1'b1, 10'h100, 11'd8, 32'd3, 32'hCAFEF00D);
    repeat (3) @(negedge clk);
    check("wait_mem_write", {31'd0, mem_write}, 32'd1);
    check("wait_mem_addr", {22'd0, mem_addr}, 32'h103);
    check("wait_mem_wdata", mem_wdata, 32'hCAFEF00D);
    check("wait_ready", {31'd0, req_ready}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_ready", {31'd0, req_ready}, 32'd1);
    check("midrst_trigger", {31'd0, mem_trigger}, 32'd0);
    check("midrst_write", {31'd0, mem_write}, 32'd0);
    check("midrst_addr", {22'd0, mem_addr}, 32'd0);
    check("midrst_wdata", mem_wdata, 32'd0);
    check("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("midrst_resp_data", resp_data, 32'd0);
    check("midrst_resp_oob", {31'd0, resp_oob}, 32'd0);
    stub_en = 1'b1;
    $display("step reset in WAIT: ready=%0d write=%0d", req_ready, mem_write);

    // 5: array block never answers
    stub_en = 1'b0;
    t0 = trig_cnt;
`ifdef ARRAY_ACCESS_TIMEOUT_EN
    send(1'b1, 10'h100, 11'd8, 32'd2, 32'h55AA55AA);
    wait_resp(40, lat);
    chk_resp("timeout", 19, 32'd0, 1'b0, 1'b1);
    check("timeout_trig_cnt", trig_cnt - t0, 1);
    post_check("timeout");
    $display("step timeout: lat=%0d timeout=%0d", lat, got_tmo);
`else
    send(1'b0, 10'h100, 11'd8, 32'd2, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (resp_valid === 1'b1) seen = 1'b1;
    end
    check("stuck_no_resp", {31'd0, seen}, 32'd0);
    check("stuck_ready", {31'd0, req_ready}, 32'd0);
    check("stuck_timeout_flag", {31'd0, resp_timeout}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("stuck_rst_ready", {31'd0, req_ready}, 32'd1);
    $display("step no done: held in WAIT for 40 cycles, ready=%0d", req_ready);
`endif
    stub_en = 1'b1;

    // Unit still serves requests afterwards.
    send(1'b0, 10'h100, 11'd8, 32'd5, 32'd0);
    wait_resp(30, lat);
    chk_resp("final_load", 6, 32'hDEADBEEF, 1'b0, 1'b0);
    post_check("final_load");
    $display("step final load idx=5: lat=%0d data=%h", lat, got_data);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
